// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One multiply (shift-add) or restoring-divide step per cycle, then a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [WIDTH-1:0]   dvd_reg, dvd_next;
  logic               is_div_reg, is_div_next;
  logic               neg_res_reg, neg_res_next;
  logic               neg_rem_reg, neg_rem_next;
  logic               div_zero_reg, div_zero_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               done_reg, done_next;

  logic               sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign sgn_op = (op == 3'd0) || (op == 3'd2);
  assign a_neg  = sgn_op & rs_data[WIDTH-1];
  assign b_neg  = sgn_op & rt_data[WIDTH-1];
  assign a_abs  = a_neg ? -rs_data : rs_data;
  assign b_abs  = b_neg ? -rt_data : rt_data;

  // Upper half holds partial product / partial remainder; lower half holds multiplier / quotient bits.
  assign mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, b_reg} : '0);
  assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};

  assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
  assign quo_fix  = neg_res_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    acc_next      = acc_reg;
    b_next        = b_reg;
    dvd_next      = dvd_reg;
    is_div_next   = is_div_reg;
    neg_res_next  = neg_res_reg;
    neg_rem_next  = neg_rem_reg;
    div_zero_next = div_zero_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          if (op[2] == 1'b0) begin
            acc_next      = {{WIDTH{1'b0}}, a_abs};
            b_next        = b_abs;
            dvd_next      = rs_data;
            is_div_next   = op[1];
            neg_res_next  = a_neg ^ b_neg;
            neg_rem_next  = a_neg;
            div_zero_next = (rt_data == '0);
            cnt_next      = '0;
            state_next    = RUN;
          end else if (op == 3'd4) begin
            hi_next   = rs_data;
            done_next = 1'b1;
          end else if (op == 3'd5) begin
            lo_next   = rs_data;
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          if (is_div_reg) begin
            acc_next = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
          end else begin
            acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
          end
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        if (!flush) begin
          done_next = 1'b1;
          if (!is_div_reg) begin
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
            lo_next = prod_fix[WIDTH-1:0];
          end else if (div_zero_reg) begin
            hi_next = dvd_reg;
            lo_next = '1;
          end else begin
            hi_next = rem_fix;
            lo_next = quo_fix;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      b_reg        <= '0;
      dvd_reg      <= '0;
      is_div_reg   <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      acc_reg      <= acc_next;
      b_reg        <= b_next;
      dvd_reg      <= dvd_next;
      is_div_reg   <= is_div_next;
      neg_res_reg  <= neg_res_next;
      neg_rem_reg  <= neg_rem_next;
      div_zero_reg <= div_zero_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      done_reg     <= done_next;
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign hi_out = hi_reg;
  assign lo_out = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         flush = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi_out, lo_out;

  int           vectors = 0;
  int           miscompares = 0;
  logic [31:0]  m_hi = '0;
  logic [31:0]  m_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib, q, r;
    logic [63:0]     res;
    res = {cur_hi, cur_lo};
    case (o)
      3'd0: begin
        sa = $signed(a);
        sb = $signed(b);
        res = sa * sb;
      end
      3'd1: begin
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = ua * ub;
      end
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          ia = a;
          ib = b;
          q = ia / ib;
          r = ia % ib;
          res = {r, q};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      3'd4: res = {a, cur_lo};
      3'd5: res = {cur_hi, a};
      default: res = {cur_hi, cur_lo};
    endcase
    return res;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit stray, input bit b2b, input string tag);
    logic [63:0] r;
    logic [31:0] hold_hi, hold_lo;
    int          cycles, busy_cnt, moved, lat_exp;
    r = ref_model(o, a, b, m_hi, m_lo);
    hold_hi = m_hi;
    hold_lo = m_lo;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0; busy_cnt = 0; moved = 0;
    while (done !== 1'b1 && cycles < 60) begin
      if (busy === 1'b1) busy_cnt++;
      if (hi_out !== hold_hi || lo_out !== hold_lo) moved++;
      if (stray && cycles == 4) begin
        start = 1'b1;
        op = 3'($urandom_range(0, 3));
        rs_data = $urandom;
        rt_data = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    m_hi = r[63:32];
    m_lo = r[31:0];
    lat_exp = (o >= 3'd4) ? 0 : W + 1;
    chk({tag, " latency"}, 32'(cycles), 32'(lat_exp));
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(lat_exp));
    chk({tag, " hold"}, 32'(moved), 32'd0);
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
    chk({tag, " hi"}, hi_out, m_hi);
    chk({tag, " lo"}, lo_out, m_lo);
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h (%0d cycles) [%s]", o, a, b, hi_out, lo_out, cycles, tag);
    if (!b2b) begin
      tick();
      chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    end
  endtask

  task automatic flush_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int n, input string tag);
    int saw_done;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    tick();
    start = 1'b0;
    saw_done = 0;
    for (int i = 1; i < n; i++) begin
      if (i == 5) begin
        start = 1'b1; op = 3'd3; rs_data = 32'd55; rt_data = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) saw_done++;
    end
    start = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk({tag, " busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " done"}, {31'b0, done}, 32'd0);
    chk({tag, " early_done"}, 32'(saw_done), 32'd0);
    chk({tag, " hi"}, hi_out, m_hi);
    chk({tag, " lo"}, lo_out, m_lo);
    tick();
    chk({tag, " done_after"}, {31'b0, done}, 32'd0);
    $display("flush op=%0d at cycle %0d -> busy=%b hi=%h lo=%h [%s]", o, n, busy, hi_out, lo_out, tag);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    tick();
    tick();
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset hi", hi_out, 32'd0);
    chk("reset lo", lo_out, 32'd0);
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi_out, lo_out);
    reset = 1'b1;
    tick();

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, "mult_neg");
    chk("mult_neg hi_const", hi_out, 32'hFFFF_FFFF);
    chk("mult_neg lo_const", lo_out, 32'hFFFF_FFF1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    chk("multu_max hi_const", hi_out, 32'hFFFF_FFFE);
    chk("multu_max lo_const", lo_out, 32'h0000_0001);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg");
    chk("div_neg lo_const", lo_out, 32'hFFFF_FFFD);
    chk("div_neg hi_const", hi_out, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd100, 32'd0, 1'b0, 1'b0, "divu_zero");
    chk("divu_zero lo_const", lo_out, 32'hFFFF_FFFF);
    chk("divu_zero hi_const", hi_out, 32'd100);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
    chk("div_ovf lo_const", lo_out, 32'h8000_0000);
    chk("div_ovf hi_const", hi_out, 32'h0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, "div_zero");
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, "div_negdvs");

    run_op(3'd4, 32'h1234_5678, 32'h0, 1'b0, 1'b1, "mthi");
    run_op(3'd5, 32'h9ABC_DEF0, 32'h0, 1'b0, 1'b0, "mtlo");
    chk("mthi hi_const", hi_out, 32'h1234_5678);
    chk("mtlo lo_const", lo_out, 32'h9ABC_DEF0);

    for (int k = 6; k < 8; k++) begin
      op = 3'(k); rs_data = 32'hDEAD_BEEF; start = 1'b1;
      tick();
      start = 1'b0;
      chk("reserved busy", {31'b0, busy}, 32'd0);
      chk("reserved done", {31'b0, done}, 32'd0);
      tick();
      chk("reserved done2", {31'b0, done}, 32'd0);
      chk("reserved hi", hi_out, m_hi);
      chk("reserved lo", lo_out, m_lo);
      $display("reserved op=%0d -> busy=%b done=%b", k, busy, done);
    end

    flush_op(3'd3, 32'd1000, 32'd7, 10, "flush_run");
    run_op(3'd3, 32'd1000, 32'd7, 1'b1, 1'b0, "divu_fresh");
    chk("divu_fresh lo_const", lo_out, 32'd142);
    chk("divu_fresh hi_const", hi_out, 32'd6);
    flush_op(3'd0, 32'd123, 32'd456, 33, "flush_fix");

    run_op(3'd0, 32'd11, 32'hFFFF_FFF0, 1'b0, 1'b1, "b2b_mult");
    run_op(3'd3, 32'd12345, 32'd100, 1'b0, 1'b0, "b2b_divu");

    for (int n = 0; n < 20; n++) begin
      ro = 3'($urandom_range(0, 5));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0), "rand");
    end

    op = 3'd0; rs_data = 32'd7; rt_data = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    #2 reset = 1'b0;
    #1;
    chk("async_rst busy", {31'b0, busy}, 32'd0);
    chk("async_rst done", {31'b0, done}, 32'd0);
    chk("async_rst hi", hi_out, 32'd0);
    chk("async_rst lo", lo_out, 32'd0);
    $display("async reset mid-op: busy=%b done=%b hi=%h lo=%h", busy, done, hi_out, lo_out);
    m_hi = '0;
    m_lo = '0;
    tick();
    reset = 1'b1;
    tick();
    run_op(3'd0, 32'd7, 32'd9, 1'b0, 1'b0, "mult_after_rst");
    chk("mult_after_rst lo_const", lo_out, 32'd63);
    chk("mult_after_rst hi_const", hi_out, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
